aes_cipher_iter_128: RTL and testbench
======================================

Name: aes_cipher_iter_128

Overview:
- Iterative AES-128 encryption datapath that consumes the 11 round keys produced by the key-expansion stage.
- Encrypts one 128-bit block at a time, executing one full AES round per clock.
- Uses 16 instances of the team's sbox cell.
- Sits between the block-input interface and the ciphertext consumer, with valid/ready handshakes on both sides.

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- key_s0..key_s10  in  128 each  round keys 0..10, word0 in [127:96], byte order as produced by key expansion
- in_valid  in  1  plaintext offered
- in_ready  out  1  block can accept a plaintext
- in_data  in  128  plaintext, byte0 in [127:120], column-major state
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  128  ciphertext, same byte order as in_data
- busy  out  1  encryption in progress

Behaviour:
- Reset (rst_n low, async): state=IDLE, in_ready=0 during reset, out_valid=0, out_data=0, busy=0, round counter=0, state register=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_reg <= in_data ^ key_s0, rnd <= 1, go to ROUND, busy=1.
- ROUND:
  - in_ready=0. Each cycle: state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), key_s[rnd]); rnd++.
  - When rnd==NR, MixColumns is bypassed (final round). The result is loaded into out_data, out_valid<=1, go to DONE.
  - Rounds 1..9 take one cycle each; round 10 takes one cycle.
- DONE:
  - out_valid=1; out_data is held stable; busy=0; in_ready=0.
  - On out_ready: out_valid<=0, go to IDLE.
  - A new block is accepted no earlier than the cycle after the out handshake; no bypass.
- Latency: accept edge at T puts out_valid high after edge T+10. Throughput is one block per 12 cycles with out_ready held high.
- Round-key mux: combinational select of key_s1..key_s10 by rnd (4-bit). rnd values 0 and 11..15 select 0.
- MixColumns: GF(2^8) xtime with reduction polynomial 0x11b. Pure combinational within a cycle.
- Handshake rules:
  - out_data/out_valid must not change while out_valid=1 && out_ready=0.
  - in_data is sampled only on the accept edge.
  - Without the optional feature, key_s0..key_s10 must remain stable from the accept edge through the final round edge. The upstream owner guarantees this; the block does not check it.
- Simultaneous events: out_ready asserted in the same cycle out_valid first rises completes the handshake on the next edge. in_valid high while not IDLE is ignored with no stall side effects.
- Reset mid-operation: the in-flight block is discarded, all outputs return to reset values immediately, and no partial ciphertext is emitted.

Optional Feature:
- Macro: AES_ITER_KEY_LATCH_EN
- Defined:
  - On the accept edge, key_s1..key_s10 are captured into internal registers (1280 flops), reset to 0.
  - Rounds use the captured copy, so upstream keys may change freely after acceptance.
  - key_s0 is still used only on the accept edge.
- Undefined:
  - No key registers; round keys are read live from the ports each round.
  - The stability requirement above applies.

Test Plan:
- FIPS-197 App. B: keys expanded from 2b7e151628aed2a6abf7158809cf4f3c, in_data=3243f6a8885a308d313198a2e0370734, out_ready=1 -> out_data=3925841d02dc09fbdc118597196a0b32, out_valid rises exactly 10 edges after the accept edge.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, in_data=00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: App. B vector with out_ready=0 for 20 cycles -> out_valid stays 1, out_data stable, in_ready=0. out_ready=1 for one cycle -> out_valid=0 and in_ready=1 next cycle.
- Back-to-back: in_valid held high with App. B then C.1 vectors, out_ready=1 -> both ciphertexts correct, in order, accept edges 12 cycles apart.
- Reset mid-op: assert rst_n=0 at round 5 -> out_valid=0, busy=0 immediately. After release, a C.1 encryption gives the correct result.
- AES_ITER_KEY_LATCH_EN defined: change key ports to all-zero keys one cycle after accept -> App. B ciphertext is still produced. With the macro undefined, the same stimulus gives a ciphertext that differs from 3925841d02dc09fbdc118597196a0b32.

Source files
------------

// File: rtl/aes_cipher_iter_128.sv
// Iterative AES-128 encryption core: one full round per clock, 16 S-box cells.
// Optional macro AES_ITER_KEY_LATCH_EN captures round keys 1..10 on the accept edge.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = 8'h00;
      aa = x;
      bb = y;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (254 = 8'b1111_1110); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (i != 0) r = gf_mul(r, x);
      end
      return r;
   endfunction

   logic [7:0] inv;

   always_comb begin
      inv = gf_inv(a);
      s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
            {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

// state | meaning
// IDLE  | waiting for a plaintext, in_ready high
// ROUND | one AES round per clock, rnd = round being applied
// DONE  | ciphertext held on out_data until out_ready
module aes_cipher_iter_128 #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] key_s0,
   input  logic [127:0] key_s1,
   input  logic [127:0] key_s2,
   input  logic [127:0] key_s3,
   input  logic [127:0] key_s4,
   input  logic [127:0] key_s5,
   input  logic [127:0] key_s6,
   input  logic [127:0] key_s7,
   input  logic [127:0] key_s8,
   input  logic [127:0] key_s9,
   input  logic [127:0] key_s10,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);
   generate
      if (NR != 10) begin : g_bad_nr
         $error("aes_cipher_iter_128 supports only NR = 10");
      end
   endgenerate

   localparam logic [3:0] NR_L = 4'(NR);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

   fsm_t         fsm;
   logic [127:0] state_reg;
   logic [3:0]   rnd;
   logic [127:0] rkey;
   logic [127:0] round_out;
   logic         last;
   logic         accept;
   logic [127:0] rk_src [1:10];

   logic [7:0] st_b [16];
   logic [7:0] sb_b [16];
   logic [7:0] sr_b [16];
   logic [7:0] mc_b [16];

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   assign accept = (fsm == IDLE) && in_valid && in_ready;
   assign last   = (rnd == NR_L);

`ifdef AES_ITER_KEY_LATCH_EN
   logic [127:0] key_q [1:10];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i <= 10; i++) key_q[i] <= '0;
      end else if (accept) begin
         key_q[1]  <= key_s1;
         key_q[2]  <= key_s2;
         key_q[3]  <= key_s3;
         key_q[4]  <= key_s4;
         key_q[5]  <= key_s5;
         key_q[6]  <= key_s6;
         key_q[7]  <= key_s7;
         key_q[8]  <= key_s8;
         key_q[9]  <= key_s9;
         key_q[10] <= key_s10;
      end
   end

   always_comb begin
      for (int i = 1; i <= 10; i++) rk_src[i] = key_q[i];
   end
`else
   always_comb begin
      rk_src[1]  = key_s1;
      rk_src[2]  = key_s2;
      rk_src[3]  = key_s3;
      rk_src[4]  = key_s4;
      rk_src[5]  = key_s5;
      rk_src[6]  = key_s6;
      rk_src[7]  = key_s7;
      rk_src[8]  = key_s8;
      rk_src[9]  = key_s9;
      rk_src[10] = key_s10;
   end
`endif

   always_comb begin
      rkey = '0;
      case (rnd)
         4'd1:    rkey = rk_src[1];
         4'd2:    rkey = rk_src[2];
         4'd3:    rkey = rk_src[3];
         4'd4:    rkey = rk_src[4];
         4'd5:    rkey = rk_src[5];
         4'd6:    rkey = rk_src[6];
         4'd7:    rkey = rk_src[7];
         4'd8:    rkey = rk_src[8];
         4'd9:    rkey = rk_src[9];
         4'd10:   rkey = rk_src[10];
         default: rkey = '0;
      endcase
   end

   // Byte i of the state sits at [127-8i -: 8]; byte index = row + 4*column.
   genvar gi, gr, gc;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_sbox
         assign st_b[gi] = state_reg[127-8*gi -: 8];
         aes_sbox u_sbox (.a(st_b[gi]), .s(sb_b[gi]));
         assign round_out[127-8*gi -: 8] = (last ? sr_b[gi] : mc_b[gi]) ^ rkey[127-8*gi -: 8];
      end
      for (gr = 0; gr < 4; gr++) begin : g_row
         for (gc = 0; gc < 4; gc++) begin : g_col
            assign sr_b[gr+4*gc] = sb_b[gr+4*((gc+gr)%4)];
         end
      end
      for (gc = 0; gc < 4; gc++) begin : g_mix
         assign mc_b[4*gc]   = xtime(sr_b[4*gc]) ^ xtime(sr_b[4*gc+1]) ^ sr_b[4*gc+1] ^
                               sr_b[4*gc+2] ^ sr_b[4*gc+3];
         assign mc_b[4*gc+1] = sr_b[4*gc] ^ xtime(sr_b[4*gc+1]) ^ xtime(sr_b[4*gc+2]) ^
                               sr_b[4*gc+2] ^ sr_b[4*gc+3];
         assign mc_b[4*gc+2] = sr_b[4*gc] ^ sr_b[4*gc+1] ^ xtime(sr_b[4*gc+2]) ^
                               xtime(sr_b[4*gc+3]) ^ sr_b[4*gc+3];
         assign mc_b[4*gc+3] = xtime(sr_b[4*gc]) ^ sr_b[4*gc] ^ sr_b[4*gc+1] ^
                               sr_b[4*gc+2] ^ xtime(sr_b[4*gc+3]);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= IDLE;
         state_reg <= '0;
         rnd       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               if (accept) begin
                  state_reg <= in_data ^ key_s0;
                  rnd       <= 4'd1;
                  busy      <= 1'b1;
                  in_ready  <= 1'b0;
                  fsm       <= ROUND;
               end else begin
                  in_ready  <= 1'b1;
               end
            end
            ROUND: begin
               state_reg <= round_out;
               rnd       <= rnd + 4'd1;
               if (last) begin
                  out_data  <= round_out;
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  fsm       <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  fsm       <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_cipher_iter_128.sv
// Directed bench for aes_cipher_iter_128 using FIPS-197 vectors.
// Expects ciphertext unchanged under AES_ITER_KEY_LATCH_EN when keys change after accept.

module tb_aes_cipher_iter_128;
   localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] rk [0:10];
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_cipher_iter_128 dut (
      .clk(clk), .rst_n(rst_n),
      .key_s0(rk[0]), .key_s1(rk[1]), .key_s2(rk[2]), .key_s3(rk[3]),
      .key_s4(rk[4]), .key_s5(rk[5]), .key_s6(rk[6]), .key_s7(rk[7]),
      .key_s8(rk[8]), .key_s9(rk[9]), .key_s10(rk[10]),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p = 8'h00; aa = x; bb = y;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   // Inverse by exhaustive search, then the affine map.
   function automatic logic [7:0] tb_sbox(input logic [7:0] a);
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
         if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
      s = 8'h63;
      for (int i = 0; i < 8; i++)
         s[i] = s[i] ^ inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
      return s;
   endfunction

   task automatic expand_key(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])} ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept_block(input logic [127:0] pt, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      in_data  = pt;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n, output bit ok);
      n = 0; ok = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (out_valid) begin
            n = i; ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      expand_key(K_B);
      #1 rst_n = 1'b0;
      #2;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      tick(); tick();
      @(negedge clk) rst_n = 1'b1;
      tick(); tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_fips_b();
      bit ok; int n;
      expand_key(K_B);
      out_ready = 1'b1;
      accept_block(PT_B, ok);
      checks++; if (!ok || busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL b_accept ok=%0d busy=%b in_ready=%b want 1 1 0", ok, busy, in_ready); end
      wait_out(n, ok);
      checks++; if (!ok || n != 10) begin errors++; $display("FAIL b_latency got %0d edges (ok=%0d) want 10", n, ok); end
      checks++; if (out_data !== CT_B) begin errors++; $display("FAIL b_data got %h want %h", out_data, CT_B); end
      checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL b_done_flags busy=%b in_ready=%b want 0 0", busy, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b_handshake out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
   endtask

   task automatic test_fips_c();
      bit ok; int n;
      expand_key(K_C);
      out_ready = 1'b1;
      accept_block(PT_C, ok);
      wait_out(n, ok);
      checks++; if (!ok || out_data !== CT_C) begin errors++; $display("FAIL c1_data got %h (ok=%0d) want %h", out_data, ok, CT_C); end
      tick();
   endtask

   task automatic test_backpressure();
      bit ok; int n; bit stable;
      expand_key(K_B);
      out_ready = 1'b0;
      accept_block(PT_B, ok);
      wait_out(n, ok);
      checks++; if (!ok || out_data !== CT_B) begin errors++; $display("FAIL bp_data got %h (ok=%0d) want %h", out_data, ok, CT_B); end
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid !== 1'b1 || out_data !== CT_B || in_ready !== 1'b0) stable = 1'b0;
      end
      checks++; if (!stable) begin errors++; $display("FAIL bp_hold out_valid=%b data=%h in_ready=%b want 1 %h 0", out_valid, out_data, in_ready, CT_B); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
   endtask

   task automatic test_back_to_back();
      int acc_cyc [2];
      logic [127:0] outs [2];
      int nacc; int nout; bit acc;
      nacc = 0; nout = 0;
      acc_cyc[0] = 0; acc_cyc[1] = 0; outs[0] = '0; outs[1] = '0;
      expand_key(K_B);
      out_ready = 1'b1;
      in_data = PT_B;
      in_valid = 1'b1;
      for (int c = 1; c <= 60 && nout < 2; c++) begin
         acc = in_ready && in_valid;
         tick();
         if (acc && nacc < 2) begin
            acc_cyc[nacc] = c;
            nacc++;
            if (nacc == 1) in_data = PT_C;
            else in_valid = 1'b0;
         end
         if (out_valid) begin
            outs[nout] = out_data;
            nout++;
            if (nout == 1) expand_key(K_C);
         end
      end
      in_valid = 1'b0;
      checks++; if (nout != 2 || nacc != 2) begin errors++; $display("FAIL b2b_count outputs=%0d accepts=%0d want 2 2", nout, nacc); end
      checks++; if (outs[0] !== CT_B) begin errors++; $display("FAIL b2b_first got %h want %h", outs[0], CT_B); end
      checks++; if (outs[1] !== CT_C) begin errors++; $display("FAIL b2b_second got %h want %h", outs[1], CT_C); end
      checks++; if (acc_cyc[1] - acc_cyc[0] != 12) begin errors++; $display("FAIL b2b_spacing got %0d want 12", acc_cyc[1] - acc_cyc[0]); end
      tick();
   endtask

   task automatic test_reset_midop();
      bit ok; int n;
      expand_key(K_B);
      out_ready = 1'b1;
      accept_block(PT_B, ok);
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midop_reset out_valid=%b busy=%b in_ready=%b want 0 0 0", out_valid, busy, in_ready); end
      tick();
      @(negedge clk) rst_n = 1'b1;
      expand_key(K_C);
      accept_block(PT_C, ok);
      wait_out(n, ok);
      checks++; if (!ok || out_data !== CT_C) begin errors++; $display("FAIL midop_after got %h (ok=%0d) want %h", out_data, ok, CT_C); end
      tick();
   endtask

   task automatic test_key_latch();
      bit ok; int n;
      expand_key(K_B);
      out_ready = 1'b1;
      accept_block(PT_B, ok);
      for (int r = 0; r <= 10; r++) rk[r] = '0;
      wait_out(n, ok);
`ifdef AES_ITER_KEY_LATCH_EN
      checks++; if (!ok || out_data !== CT_B) begin errors++; $display("FAIL key_latch got %h (ok=%0d) want %h", out_data, ok, CT_B); end
`else
      checks++; if (!ok || out_data === CT_B) begin errors++; $display("FAIL key_live got %h (ok=%0d) want value differing from %h", out_data, ok, CT_B); end
`endif
      tick();
   endtask

   initial begin
      test_reset();
      test_fips_b();
      test_fips_c();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
      test_key_latch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
